// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for a combinational bitwise ALU.
// Successive load presses capture operand A, then operand B. The ALU result is
// captured one cycle later and held until the next operation starts.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds registered zero/parity result flags.
module alu_operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             clear,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] op_count,
    output logic             flag_zero,
    output logic             flag_parity
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state_q;
    logic   load_prev;
    logic   load_armed;
    logic   load_ev;

    // load_armed stays low after reset until load is seen low, so a press held
    // across reset release does not count as a new event.
    assign load_ev = load & ~load_prev & load_armed;
    assign state   = state_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_zero_q;
    logic flag_parity_q;

    function automatic logic calc_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic calc_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    assign flag_zero   = flag_zero_q;
    assign flag_parity = flag_parity_q;
`else
    assign flag_zero   = 1'b0;
    assign flag_parity = 1'b0;
`endif

    // Load rising-edge history and post-reset arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_prev  <= 1'b0;
            load_armed <= 1'b0;
        end else begin
            load_prev  <= load;
            load_armed <= load_armed | ~load;
        end
    end

    // Operand sequencing FSM with registered operands, result, flags and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD_A;
            a_out        <= '0;
            b_out        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            op_count     <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            flag_zero_q   <= 1'b0;
            flag_parity_q <= 1'b0;
`endif
        end else if (clear) begin
            // Abort wins over any load event; the operation count is kept.
            state_q      <= LOAD_A;
            a_out        <= '0;
            b_out        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            flag_zero_q   <= 1'b0;
            flag_parity_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    if (load_ev) begin
                        a_out   <= data_in;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (load_ev) begin
                        b_out   <= data_in;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Single-cycle capture; load events here are dropped.
                    result       <= alu_x;
                    result_valid <= 1'b1;
                    op_count     <= op_count + CNT_W'(1);
                    state_q      <= HOLD;
`ifdef ALU_SEQ_FLAGS_EN
                    flag_zero_q   <= calc_zero(alu_x);
                    flag_parity_q <= calc_parity(alu_x);
`endif
                end
                HOLD: begin
                    // Next operation starts directly with A; result is kept.
                    if (load_ev) begin
                        a_out        <= data_in;
                        result_valid <= 1'b0;
                        state_q      <= LOAD_B;
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with an XOR model standing in for the ALU.
module tb_alu_operand_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       load;
    logic       clear;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [7:0] alu_x;
    logic [7:0] result;
    logic       result_valid;
    logic [1:0] state;
    logic [7:0] op_count;
    logic       flag_zero;
    logic       flag_parity;

    int n_pass;
    int n_total;
    logic [7:0] exp_cnt;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[6];

    alu_operand_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .load         (load),
        .clear        (clear),
        .a_out        (a_out),
        .b_out        (b_out),
        .alu_x        (alu_x),
        .result       (result),
        .result_valid (result_valid),
        .state        (state),
        .op_count     (op_count),
        .flag_zero    (flag_zero),
        .flag_parity  (flag_parity)
    );

    // Downstream bitwise ALU model
    assign alu_x = a_out ^ b_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d);
        data_in = d;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b);
        pulse(a);
        pulse(b);
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic check_flags(input string name, input logic [7:0] res);
`ifdef ALU_SEQ_FLAGS_EN
        check({name, "_fz"}, flag_zero, res == 8'h00);
        check({name, "_fp"}, flag_parity, ^res);
`else
        check({name, "_fz"}, flag_zero, 1'b0);
        check({name, "_fp"}, flag_parity, 1'b0);
`endif
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        exp_cnt = 8'd0;
        rst = 1'b1;
        data_in = 8'h00;
        load = 1'b0;
        clear = 1'b0;

        vecs[0] = '{8'hFF, 8'hFF, 8'h00};
        vecs[1] = '{8'h00, 8'hFF, 8'hFF};
        vecs[2] = '{8'h12, 8'h34, 8'h26};
        vecs[3] = '{8'h80, 8'h01, 8'h81};
        vecs[4] = '{8'hF0, 8'h0F, 8'hFF};
        vecs[5] = '{8'h5A, 8'h5B, 8'h01};

        // Reset state
        tick();
        tick();
        check("rst_state", state, 2'd0);
        check("rst_a", a_out, 8'h00);
        check("rst_b", b_out, 8'h00);
        check("rst_res", result, 8'h00);
        check("rst_vld", result_valid, 1'b0);
        check("rst_cnt", op_count, 8'h00);
        check_flags("rst", 8'h00);
        rst = 1'b0;
        tick();

        // Basic operation with exact latency
        pulse(8'hA5);
        check("a_load", a_out, 8'hA5);
        check("a_state", state, 2'd1);
        data_in = 8'h0F;
        load = 1'b1;
        tick();
        check("b_load", b_out, 8'h0F);
        check("b_state_exec", state, 2'd2);
        check("b_vld_early", result_valid, 1'b0);
        load = 1'b0;
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("exec_vld", result_valid, 1'b1);
        check("exec_res", result, 8'hAA);
        check("exec_state", state, 2'd3);
        check("exec_cnt", op_count, exp_cnt);
        tick();
        tick();
        check("hold_state", state, 2'd3);
        check("hold_res", result, 8'hAA);

        // New A from HOLD
        pulse(8'h33);
        check("hold_vld", result_valid, 1'b0);
        check("hold_res_kept", result, 8'hAA);
        check("hold_a", a_out, 8'h33);
        check("hold_b_kept", b_out, 8'h0F);
        check("hold_next", state, 2'd1);

        // Clear coincident with load in LOAD_B
        data_in = 8'h55;
        load = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load = 1'b0;
        check("clr_state", state, 2'd0);
        check("clr_a", a_out, 8'h00);
        check("clr_b", b_out, 8'h00);
        check("clr_res", result, 8'h00);
        check("clr_vld", result_valid, 1'b0);
        check("clr_cnt", op_count, exp_cnt);
        tick();

        // Load held high for 10 cycles gives one capture
        load = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = (i == 0) ? 8'hC3 : 8'(i);
            tick();
        end
        check("held_a", a_out, 8'hC3);
        check("held_state", state, 2'd1);
        check("held_b", b_out, 8'h00);
        load = 1'b0;
        tick();
        pulse(8'h3C);
        exp_cnt = exp_cnt + 8'd1;
        check("held_res", result, 8'hFF);
        check("held_cnt", op_count, exp_cnt);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_a", i), a_out, vecs[i].a);
            check($sformatf("vec%0d_b", i), b_out, vecs[i].b);
            check($sformatf("vec%0d_res", i), result, vecs[i].exp_res);
            check($sformatf("vec%0d_vld", i), result_valid, 1'b1);
            check($sformatf("vec%0d_cnt", i), op_count, exp_cnt);
            check_flags($sformatf("vec%0d", i), vecs[i].exp_res);
        end

        // Clear during EXEC aborts capture
        pulse(8'h11);
        data_in = 8'h22;
        load = 1'b1;
        tick();
        check("abort_exec", state, 2'd2);
        load = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_state", state, 2'd0);
        check("abort_vld", result_valid, 1'b0);
        check("abort_res", result, 8'h00);
        check("abort_cnt", op_count, exp_cnt);
        tick();

        // Counter wrap
        while (exp_cnt != 8'hFF) do_op(8'h01, 8'h02);
        check("wrap_pre", op_count, 8'hFF);
        do_op(8'hFF, 8'hFF);
        check("wrap_cnt", op_count, 8'h00);
        check("wrap_vld", result_valid, 1'b1);
        check_flags("wrap", 8'h00);

        // Asynchronous reset mid LOAD_B
        pulse(8'h77);
        check("arst_pre", state, 2'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", state, 2'd0);
        check("arst_a", a_out, 8'h00);
        check("arst_cnt", op_count, 8'h00);
        check("arst_vld", result_valid, 1'b0);
        exp_cnt = 8'd0;

        // Load held across reset release is not an event
        load = 1'b1;
        data_in = 8'h9A;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("heldrst_state", state, 2'd0);
        check("heldrst_a", a_out, 8'h00);
        load = 1'b0;
        tick();
        pulse(8'h9A);
        check("postrst_a", a_out, 8'h9A);
        check("postrst_state", state, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
